// File: rtl/rx78_cart_loader.sv
// Cartridge loader: copies the HPS cart download into 32K cart RAM, pads the tail with 0xFF
// and holds the CPU in reset. Define RX78_LOADER_VRAM_CLEAR_EN to also zero VRAM before release.
`timescale 1ns/1ps
module rx78_cart_loader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  dl_index,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        cart_we,
  output logic [14:0] cart_addr,
  output logic [7:0]  cart_data,
  output logic        vram_clr_we,
  output logic [12:0] vram_clr_addr,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] cart_len
);

  localparam logic [7:0]  CART_INDEX = 8'd1;
  localparam logic [15:0] CART_SIZE  = 16'h8000;
  localparam logic [14:0] PAD_LAST   = 15'h7FFF;
  localparam logic [3:0]  HOLD_LAST  = 4'd15;

  typedef enum logic [2:0] {IDLE, LOAD, PAD, CLEAR, RELEASE} state_t;

  state_t      state;
  logic [14:0] pad_addr;
  logic [3:0]  rel_cnt;
  logic        cart_start;
  logic        in_range;
  logic [15:0] byte_end;

  assign cart_start = dl_active && (dl_index == CART_INDEX);
  assign in_range   = (dl_addr[24:15] == '0);
  assign byte_end   = {1'b0, dl_addr[14:0]} + 16'd1;
  assign busy       = cpu_hold;

  function automatic state_t after_pad();
`ifdef RX78_LOADER_VRAM_CLEAR_EN
    return CLEAR;
`else
    return RELEASE;
`endif
  endfunction

`ifdef RX78_LOADER_VRAM_CLEAR_EN
  localparam logic [12:0] CLR_LAST = 13'h1FFF;
  logic [12:0] clr_cnt;
`else
  assign vram_clr_we   = 1'b0;
  assign vram_clr_addr = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      cart_len  <= '0;
      cart_we   <= 1'b0;
      cart_addr <= '0;
      cart_data <= '0;
      pad_addr  <= '0;
      rel_cnt   <= '0;
`ifdef RX78_LOADER_VRAM_CLEAR_EN
      vram_clr_we   <= 1'b0;
      vram_clr_addr <= '0;
      clr_cnt       <= '0;
`endif
    end else begin
      cart_we <= 1'b0;
      done    <= 1'b0;
      if (state != RELEASE) rel_cnt <= '0;
`ifdef RX78_LOADER_VRAM_CLEAR_EN
      vram_clr_we <= 1'b0;
      if (state != CLEAR) clr_cnt <= '0;
`endif
      // A cart download starting anywhere outside LOAD restarts the whole sequence.
      if (cart_start && (state != LOAD)) begin
        state    <= LOAD;
        cpu_hold <= 1'b1;
        cart_len <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            if (!dl_active) begin
              pad_addr <= cart_len[14:0];
              state    <= (cart_len == CART_SIZE) ? after_pad() : PAD;
            end else if (dl_wr && (dl_index == CART_INDEX)) begin
              if (in_range) begin
                cart_we   <= 1'b1;
                cart_addr <= dl_addr[14:0];
                cart_data <= dl_data;
                if (byte_end > cart_len) cart_len <= byte_end;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          PAD: begin
            cart_we   <= 1'b1;
            cart_addr <= pad_addr;
            cart_data <= 8'hFF;
            if (pad_addr == PAD_LAST) state <= after_pad();
            else pad_addr <= pad_addr + 15'd1;
          end
          CLEAR: begin
`ifdef RX78_LOADER_VRAM_CLEAR_EN
            vram_clr_we   <= 1'b1;
            vram_clr_addr <= clr_cnt;
            if (clr_cnt == CLR_LAST) state <= RELEASE;
            else clr_cnt <= clr_cnt + 13'd1;
`else
            state <= RELEASE;
`endif
          end
          RELEASE: begin
            if (rel_cnt == HOLD_LAST) begin
              state    <= IDLE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              rel_cnt <= rel_cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx78_cart_loader.sv
// Scoreboard bench for rx78_cart_loader: stimulus pushes expected RAM/VRAM writes, a monitor pops them.
`timescale 1ns/1ps
module tb_rx78_cart_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  dl_index;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cart_we;
  logic [14:0] cart_addr;
  logic [7:0]  cart_data;
  logic        vram_clr_we;
  logic [12:0] vram_clr_addr;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] cart_len;

  rx78_cart_loader dut (
    .clk(clk), .reset_n(reset_n), .dl_index(dl_index), .dl_active(dl_active),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .cart_we(cart_we),
    .cart_addr(cart_addr), .cart_data(cart_data), .vram_clr_we(vram_clr_we),
    .vram_clr_addr(vram_clr_addr), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .overflow(overflow), .cart_len(cart_len)
  );

  always #5 clk = ~clk;

  typedef struct { logic [14:0] a; logic [7:0] d; } wr_t;
  wr_t         cq[$];
  logic [12:0] vq[$];

  int checks = 0, failures = 0;
  int cyc = 0, last_wr_cyc = 0, done_cyc = 0, done_cnt = 0, n_cart = 0, n_clr = 0;
  int drop_cyc = 0;
  bit prev_hold = 1'b0;
  bit m_loading = 1'b0, m_ovf = 1'b0, m_tail_write = 1'b0;
  int m_len = 0;
  wr_t mon_e;
  logic [12:0] mon_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [57:0] outs();
    return {cart_we, cart_addr, cart_data, vram_clr_we, vram_clr_addr,
            cpu_hold, busy, done, overflow, cart_len};
  endfunction

  // Monitor: every DUT write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cart_we) begin
        chk("we_exclusive", vram_clr_we, 0);
        if (cq.size() == 0) chk("cart_unexpected_we", cart_we, 0);
        else begin
          mon_e = cq.pop_front();
          chk("cart_addr", cart_addr, mon_e.a);
          chk("cart_data", cart_data, mon_e.d);
        end
        n_cart++;
        last_wr_cyc = cyc;
      end
      if (vram_clr_we) begin
        if (vq.size() == 0) chk("vram_unexpected_we", vram_clr_we, 0);
        else begin
          mon_v = vq.pop_front();
          chk("vram_clr_addr", vram_clr_addr, mon_v);
        end
        n_clr++;
        last_wr_cyc = cyc;
      end
`ifndef RX78_LOADER_VRAM_CLEAR_EN
      if (vram_clr_we || (vram_clr_addr != 13'd0)) chk("vram_idle", {vram_clr_we, vram_clr_addr}, 0);
`endif
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("hold_before_done", prev_hold, 1);
      end
      prev_hold = cpu_hold;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bit was_busy;
    was_busy  = busy;
    dl_index  = idx;
    dl_active = 1'b1;
    if (idx == 8'd1) begin
      m_loading = 1'b1;
      m_len     = 0;
      m_ovf     = 1'b0;
    end
    step();
    step();
    chk("busy_after_start", busy, m_loading || was_busy);
    chk("hold_after_start", cpu_hold, m_loading || was_busy);
    if (m_loading) begin
      chk("len_cleared", cart_len, 0);
      chk("ovf_cleared", overflow, 0);
    end
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    bit acc, wr;
    acc = m_loading && dl_active && (dl_index == 8'd1);
    wr  = acc && (int'(a) < 'h8000);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    if (wr) begin
      cq.push_back('{a: a[14:0], d: d});
      if (int'(a) + 1 > m_len) m_len = int'(a) + 1;
    end else if (acc) begin
      m_ovf = 1'b1;
    end
    step();
    dl_wr = 1'b0;
    chk("write_latency", cart_we, wr);
    if (acc) chk("ovf_flag", overflow, m_ovf);
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic end_load();
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    drop_cyc  = cyc;
    for (int x = m_len; x < 'h8000; x++) cq.push_back('{a: 15'(x), d: 8'hFF});
`ifdef RX78_LOADER_VRAM_CLEAR_EN
    for (int x = 0; x < 8192; x++) vq.push_back(13'(x));
    m_tail_write = 1'b1;
`else
    m_tail_write = (m_len != 'h8000);
`endif
    m_loading = 1'b0;
  endtask

  task automatic wait_done();
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while ((done_cnt == d0) && (k < 60000)) begin
      step();
      k++;
    end
    chk("done_seen", done_cnt, d0 + 1);
    if (done_cnt != d0) begin
      if (m_tail_write) chk("release_len", done_cyc - last_wr_cyc, 16);
      else chk("release_len_nopad", done_cyc - drop_cyc, 17);
      chk("hold_dropped", cpu_hold, 0);
      chk("busy_dropped", busy, 0);
      step();
      chk("done_width", done, 0);
      chk("done_once", done_cnt, d0 + 1);
    end
    chk("cart_q_drained", cq.size(), 0);
    chk("vram_q_drained", vq.size(), 0);
    chk("cart_len", cart_len, m_len);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic wait_progress(input int base_cart, input int base_clr, input int need);
    int k;
    k = 0;
`ifdef RX78_LOADER_VRAM_CLEAR_EN
    while ((n_clr - base_clr < need) && (k < 20000)) begin step(); k++; end
    if (k == 20000) chk("clear_progress", n_clr - base_clr, need);
`else
    while ((n_cart - base_cart < need) && (k < 40000)) begin step(); k++; end
    if (k == 40000) chk("pad_progress", n_cart - base_cart, need);
`endif
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog cycles=%0d limit=120000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_c, base_v, d0;
    reset_n = 1'b0; dl_index = 8'd0; dl_active = 1'b0; dl_wr = 1'b0;
    dl_addr = '0; dl_data = '0;
    #1;
    chk("reset_outputs_noclk", outs(), 0);
    repeat (3) step();
    chk("reset_outputs", outs(), 0);
    reset_n = 1'b1;
    step();
    chk("idle_after_reset", outs(), 0);

    // Strobes outside a cart download are ignored.
    send(25'd5, 8'hAA);
    start_dl(8'd2);
    for (int i = 0; i < 6; i++) send(25'($urandom_range(0, 'h7FFF)), 8'($urandom));
    dl_active = 1'b0;
    repeat (3) step();
    chk("index2_busy", busy, 0);
    chk("index2_len", cart_len, 0);
    chk("index2_done", done_cnt, 0);

    // Four bytes, then the long 0xFF pad.
    start_dl(8'd1);
    send(25'd0, 8'h11); send(25'd1, 8'h22); send(25'd2, 8'h33); send(25'd3, 8'h44);
    end_load();
    wait_done();

    // Full-size image with overflow bytes: no pad.
    start_dl(8'd1);
    send(25'h7FFF, 8'($urandom));
    for (int i = 0; i < 20; i++) send(25'(32'h7000 + $urandom_range(0, 'hFFE)), 8'($urandom));
    send(25'h8000, 8'h5A);
    send(25'h1FFFFFF, 8'($urandom));
    end_load();
    wait_done();

    // Random bytes near the top; a strobe with a foreign index mid-load is dropped.
    start_dl(8'd1);
    for (int i = 0; i < 30; i++) send(25'(32'h7E00 + $urandom_range(0, 'h1FE)), 8'($urandom));
    dl_index = 8'd2;
    send(25'h7FFE, 8'h77);
    dl_index = 8'd1;
    send(25'(32'h7F00 + $urandom_range(0, 'hF)), 8'($urandom));
    end_load();
    wait_done();

    // New download during the tail phase aborts it.
    start_dl(8'd1);
    send(25'h7BFF, 8'($urandom));
    for (int i = 0; i < 8; i++) send(25'(32'h7C00 + $urandom_range(0, 'h3F)), 8'($urandom));
    base_c = n_cart; base_v = n_clr; d0 = done_cnt;
    end_load();
    wait_progress(base_c, base_v, 100);
    start_dl(8'd1);
    cq.delete();
    vq.delete();
    chk("abort_no_done", done_cnt, d0);
    send(25'(32'h7FF0 + $urandom_range(0, 'hF)), 8'($urandom));
    send(25'(32'h7FE0 + $urandom_range(0, 'hF)), 8'($urandom));
    end_load();
    wait_done();

    // Asynchronous reset mid-sequence, then a clean restart.
    start_dl(8'd1);
    send(25'h7F00, 8'($urandom));
    base_c = n_cart; base_v = n_clr; d0 = done_cnt;
    end_load();
`ifdef RX78_LOADER_VRAM_CLEAR_EN
    wait_progress(base_c, base_v, 'h801);
`else
    wait_progress(base_c, base_v, 50);
`endif
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", outs(), 0);
    cq.delete();
    vq.delete();
    repeat (2) step();
    chk("reset_held_outputs", outs(), 0);
    reset_n = 1'b1;
    repeat (3) step();
    chk("post_reset_idle", outs(), 0);
    chk("post_reset_no_done", done_cnt, d0);
    start_dl(8'd1);
    for (int i = 0; i < 5; i++) send(25'(32'h7FC0 + $urandom_range(0, 'h3F)), 8'($urandom));
    end_load();
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
